// File: rtl/mmio_peripheral.sv
// Memory-mapped MEM-stage peripheral: reloading timer with interrupt, LED/switch/7-segment
// registers and an 8N1 UART transmitter/receiver, all decoded at 0x4000_00xx.
module mmio_peripheral #(
   parameter int BAUD_DIV = 5208
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        UART_RX,
   output logic        UART_TX,
   output logic [7:0]  led,
   input  logic [7:0]  switch,
   output logic [11:0] digi,
   output logic        irq,
   input  logic        kernel
);

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_DIGI = 32'h4000_0014;
   localparam logic [31:0] A_TXD  = 32'h4000_0018;
   localparam logic [31:0] A_RXD  = 32'h4000_001C;
   localparam logic [31:0] A_UCON = 32'h4000_0020;

   localparam int               CNT_W     = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   logic [31:0] r_th, r_tl;
   logic [2:0]  r_tcon;
   logic [7:0]  r_led;
   logic [11:0] r_digi;

   logic w_wr_th, w_wr_tl, w_wr_tcon, w_wr_led, w_wr_digi, w_wr_txd;
   logic w_rd_rxd, w_rd_ucon, w_tl_wrap;

   assign w_wr_th   = wr && (addr == A_TH);
   assign w_wr_tl   = wr && (addr == A_TL);
   assign w_wr_tcon = wr && (addr == A_TCON);
   assign w_wr_led  = wr && (addr == A_LED);
   assign w_wr_digi = wr && (addr == A_DIGI);
   assign w_wr_txd  = wr && (addr == A_TXD);
   assign w_rd_rxd  = rd && (addr == A_RXD);
   assign w_rd_ucon = rd && (addr == A_UCON);
   assign w_tl_wrap = (r_tl == 32'hFFFF_FFFF);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_th   <= '0;
         r_tl   <= '0;
         r_tcon <= '0;
         r_led  <= '0;
         r_digi <= '0;
      end else begin
         if (w_wr_th) r_th <= wdata;
         // Bus writes take priority over the counting/reload hardware.
         if (w_wr_tl)        r_tl <= wdata;
         else if (r_tcon[0]) r_tl <= w_tl_wrap ? r_th : r_tl + 32'd1;
         if (w_wr_tcon)                   r_tcon    <= wdata[2:0];
         else if (r_tcon[0] && w_tl_wrap) r_tcon[2] <= r_tcon[2] | r_tcon[1];
         if (w_wr_led)  r_led  <= wdata[7:0];
         if (w_wr_digi) r_digi <= wdata[11:0];
      end
   end

   assign led  = r_led;
   assign digi = r_digi;
   assign irq  = r_tcon[1] & r_tcon[2] & ~kernel;

   // UART transmitter
   uart_state_e      r_tx_state, w_tx_state_nxt;
   logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
   logic [2:0]       r_tx_bit, w_tx_bit_nxt;
   logic [7:0]       r_tx_data;
   logic             r_uart_tx, r_tx_done;
   logic             w_tx_load, w_tx_done_set, w_tx_line, w_tx_busy;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_load      = 1'b0;
      w_tx_done_set  = 1'b0;
      case (r_tx_state)
         S_IDLE: begin
            w_tx_cnt_nxt = '0;
            if (w_wr_txd) begin
               w_tx_state_nxt = S_START;
               w_tx_load      = 1'b1;
            end
         end
         S_START: if (r_tx_cnt == BAUD_LAST) begin
            w_tx_state_nxt = S_DATA;
            w_tx_cnt_nxt   = '0;
            w_tx_bit_nxt   = '0;
         end
         S_DATA: if (r_tx_cnt == BAUD_LAST) begin
            w_tx_cnt_nxt = '0;
            if (r_tx_bit == 3'd7) w_tx_state_nxt = S_STOP;
            else                  w_tx_bit_nxt   = r_tx_bit + 3'd1;
         end
         default: if (r_tx_cnt == BAUD_LAST) begin
            w_tx_state_nxt = S_IDLE;
            w_tx_cnt_nxt   = '0;
            w_tx_done_set  = 1'b1;
         end
      endcase
      // Line level follows the next state so the start bit appears the cycle after the TXD write.
      case (w_tx_state_nxt)
         S_START: w_tx_line = 1'b0;
         S_DATA:  w_tx_line = r_tx_data[w_tx_bit_nxt];
         default: w_tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_data  <= '0;
         r_uart_tx  <= 1'b1;
         r_tx_done  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_uart_tx  <= w_tx_line;
         if (w_tx_load) r_tx_data <= wdata[7:0];
         if (w_tx_done_set)  r_tx_done <= 1'b1;
         else if (w_rd_ucon) r_tx_done <= 1'b0;
      end
   end

   assign UART_TX   = r_uart_tx;
   assign w_tx_busy = (r_tx_state != S_IDLE);

   // UART receiver
   uart_state_e      r_rx_state, w_rx_state_nxt;
   logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]       r_rx_bit, w_rx_bit_nxt;
   logic [7:0]       r_rx_shift, r_rxd;
   logic             r_rx_sync1, r_rx_sync2, r_rx_d, r_rx_valid;
   logic             w_rx_fall, w_rx_shift_en, w_rx_set;

   assign w_rx_fall = r_rx_d & ~r_rx_sync2;

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift_en  = 1'b0;
      w_rx_set       = 1'b0;
      case (r_rx_state)
         S_IDLE: begin
            w_rx_cnt_nxt = '0;
            if (w_rx_fall) w_rx_state_nxt = S_START;
         end
         S_START: if (r_rx_cnt == HALF_LAST) begin
            w_rx_state_nxt = r_rx_sync2 ? S_IDLE : S_DATA;
            w_rx_cnt_nxt   = '0;
            w_rx_bit_nxt   = '0;
         end
         S_DATA: if (r_rx_cnt == BAUD_LAST) begin
            w_rx_cnt_nxt  = '0;
            w_rx_shift_en = 1'b1;
            if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
            else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
         end
         default: if (r_rx_cnt == BAUD_LAST) begin
            w_rx_state_nxt = S_IDLE;
            w_rx_cnt_nxt   = '0;
            w_rx_set       = r_rx_sync2;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_d     <= 1'b1;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rxd      <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_sync1 <= UART_RX;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_d     <= r_rx_sync2;
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         if (w_rx_shift_en) r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
         if (w_rx_set) r_rxd <= r_rx_shift;
         if (w_rx_set)      r_rx_valid <= 1'b1;
         else if (w_rd_rxd) r_rx_valid <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (addr)
            A_TH:    rdata = r_th;
            A_TL:    rdata = r_tl;
            A_TCON:  rdata = {29'd0, r_tcon};
            A_LED:   rdata = {24'd0, r_led};
            A_SW:    rdata = {24'd0, switch};
            A_DIGI:  rdata = {20'd0, r_digi};
            A_TXD:   rdata = {24'd0, r_tx_data};
            A_RXD:   rdata = {24'd0, r_rxd};
            A_UCON:  rdata = {29'd0, w_tx_busy, r_rx_valid, r_tx_done};
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral: bus registers, timer/irq, UART TX and RX,
// using a queue of expected values filled when stimulus is driven.
module tb_mmio_peripheral;

   localparam int BAUD = 8;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_DIGI = 32'h4000_0014;
   localparam logic [31:0] A_TXD  = 32'h4000_0018;
   localparam logic [31:0] A_RXD  = 32'h4000_001C;
   localparam logic [31:0] A_UCON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic [7:0]  led;
   logic [7:0]  sw = '0;
   logic [11:0] digi;
   logic        irq;
   logic        kernel = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   mmio_peripheral #(.BAUD_DIV(BAUD)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .UART_RX(uart_rx), .UART_TX(uart_tx), .led(led),
      .switch(sw), .digi(digi), .irq(irq), .kernel(kernel)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      rd = 1'b1;
      addr = a;
      #1 d = rdata;
      @(posedge clk);
      #1 rd = 1'b0;
      addr = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr = 1'b1;
      addr = a;
      wdata = d;
      @(posedge clk);
      #1 wr = 1'b0;
      addr = '0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         uart_rx = bits[i];
         repeat (BAUD) @(negedge clk);
      end
      uart_rx = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] d, e;
      logic [31:0] regs[5];
      bus_write(A_TCON, 32'h7);
      bus_write(A_LED, 32'h5A);
      bus_write(A_DIGI, 32'h123);
      bus_write(A_TH, 32'h1234);
      bus_write(A_TXD, 32'h55);
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL pre_reset_irq: got %b expected 1", irq);
      end
      repeat (20) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (uart_tx !== 1'b1 || irq !== 1'b0 || led !== 8'h0 || digi !== 12'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got tx=%b irq=%b led=%h digi=%h expected tx=1 irq=0 led=00 digi=000",
                  uart_tx, irq, led, digi);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      regs = '{A_UCON, A_TH, A_TL, A_TCON, A_RXD};
      for (int i = 0; i < 5; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 5; i++) begin
         bus_read(regs[i], d);
         e = exp_q.pop_front();
         n_checks++;
         if (d !== e) begin
            n_errors++;
            $display("FAIL reset_reg_%h: got %h expected %h", regs[i], d, e);
         end
      end
   endtask

   task automatic test_timer;
      logic [31:0] d, e;
      kernel = 1'b0;
      bus_write(A_TH, 32'hFFFF_FFFC);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h3);
      exp_q.push_back(32'hFFFF_FFFE);
      exp_q.push_back(32'hFFFF_FFFF);
      exp_q.push_back(32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) begin
         bus_read(A_TL, d);
         e = exp_q.pop_front();
         n_checks++;
         if (d !== e) begin
            n_errors++;
            $display("FAIL timer_tl_%0d: got %h expected %h", i, d, e);
         end
      end
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL timer_irq_after_reload: got %b expected 1", irq);
      end
      kernel = 1'b1;
      #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL timer_irq_kernel_mask: got %b expected 0", irq);
      end
      kernel = 1'b0;
      #1;
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL timer_irq_unmask: got %b expected 1", irq);
      end
      bus_write(A_TCON, 32'h3);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL timer_irq_clear: got %b expected 0", irq);
      end
      bus_write(A_TCON, 32'h0);
   endtask

   task automatic test_tx;
      logic [31:0] d;
      logic [9:0]  frame;
      frame = {1'b1, 8'hA5, 1'b0};
      bus_write(A_TXD, 32'hA5);
      for (int i = 0; i < 10; i++) exp_q.push_back({31'd0, frame[i]});
      fork
         begin
            logic [31:0] e;
            for (int b = 0; b < 10; b++) begin
               e = exp_q.pop_front();
               for (int c = 0; c < BAUD; c++) begin
                  @(negedge clk);
                  n_checks++;
                  if (uart_tx !== e[0]) begin
                     n_errors++;
                     $display("FAIL tx_bit%0d_cyc%0d: got %b expected %b", b, c, uart_tx, e[0]);
                  end
               end
            end
         end
         begin
            logic [31:0] u;
            repeat (20) @(posedge clk);
            bus_read(A_UCON, u);
            n_checks++;
            if (u !== 32'h4) begin
               n_errors++;
               $display("FAIL tx_ucon_busy: got %h expected 00000004", u);
            end
            bus_write(A_TXD, 32'h3C);
            bus_read(A_UCON, u);
            n_checks++;
            if (u !== 32'h4) begin
               n_errors++;
               $display("FAIL tx_ucon_busy2: got %h expected 00000004", u);
            end
         end
      join
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h1) begin
         n_errors++;
         $display("FAIL tx_ucon_done: got %h expected 00000001", d);
      end
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL tx_ucon_cleared: got %h expected 00000000", d);
      end
   endtask

   task automatic test_rx;
      logic [31:0] d, e;
      exp_q.push_back(32'h5A);
      send_frame(8'h5A, 1'b1);
      repeat (4) @(posedge clk);
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h2) begin
         n_errors++;
         $display("FAIL rx_valid_set: got %h expected 00000002", d);
      end
      bus_read(A_RXD, d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin
         n_errors++;
         $display("FAIL rx_data: got %h expected %h", d, e);
      end
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL rx_valid_cleared: got %h expected 00000000", d);
      end
   endtask

   task automatic test_rx_glitch;
      logic [31:0] d;
      @(negedge clk) uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4 * BAUD) @(posedge clk);
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL rx_glitch_reject: got %h expected 00000000", d);
      end
   endtask

   task automatic test_rx_framing;
      logic [31:0] d;
      send_frame(8'h33, 1'b0);
      repeat (2 * BAUD) @(posedge clk);
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL rx_framing_discard: got %h expected 00000000", d);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d, e;
      send_frame(8'h11, 1'b1);
      send_frame(8'hE7, 1'b1);
      exp_q.push_back(32'hE7);
      repeat (4) @(posedge clk);
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h2) begin
         n_errors++;
         $display("FAIL b2b_valid: got %h expected 00000002", d);
      end
      bus_read(A_RXD, d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin
         n_errors++;
         $display("FAIL b2b_overrun_data: got %h expected %h", d, e);
      end
   endtask

   task automatic test_bus_misc;
      logic [31:0] d, e;
      sw = 8'h81;
      exp_q.push_back(32'h81);
      bus_read(A_SW, d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin
         n_errors++;
         $display("FAIL switch_read: got %h expected %h", d, e);
      end
      bus_write(A_LED, 32'h1FF);
      n_checks++;
      if (led !== 8'hFF) begin
         n_errors++;
         $display("FAIL led_port: got %h expected ff", led);
      end
      exp_q.push_back(32'hFF);
      bus_read(A_LED, d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin
         n_errors++;
         $display("FAIL led_read: got %h expected %h", d, e);
      end
      bus_write(A_DIGI, 32'hFABC);
      n_checks++;
      if (digi !== 12'hABC) begin
         n_errors++;
         $display("FAIL digi_port: got %h expected abc", digi);
      end
      bus_read(32'h4000_0024, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL unmapped_read: got %h expected 00000000", d);
      end
      bus_write(A_UCON, 32'h7);
      bus_read(A_UCON, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL ucon_write_ignored: got %h expected 00000000", d);
      end
      @(negedge clk);
      addr = A_LED;
      rd = 1'b0;
      #1;
      n_checks++;
      if (rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL rd_low_zero: got %h expected 00000000", rdata);
      end
      addr = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      test_reset();
      test_timer();
      test_tx();
      test_rx();
      test_rx_glitch();
      test_rx_framing();
      test_back_to_back();
      test_bus_misc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmio_peripheral.md
Name: mmio_peripheral

Overview:
- Memory-mapped peripheral block on the MEM-stage data bus of the pipelined CPU; consumes MEM_MemRd/MEM_MemWr/MEM_ALUOut/MEM_DataBusB.
- Returns read data to the MEM_MemOut mux when address bit 30 = 1.
- Contains a reloading 32-bit timer with interrupt, LED/switch/7-segment registers, and an 8N1 UART transmitter and receiver.
- Drives IRQ to Control; IRQ is masked while the CPU runs in kernel mode (PC[31]).

Parameters:
- BAUD_DIV, 5208: clk cycles per UART bit (50 MHz / 9600); must be >= 4.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- rd  in  1  bus read strobe (MEM_MemRd)
- wr  in  1  bus write strobe (MEM_MemWr)
- addr  in  32  byte address (MEM_ALUOut)
- wdata  in  32  write data (MEM_DataBusB)
- rdata  out  32  read data, combinational
- UART_RX  in  1  serial input, asynchronous
- UART_TX  out  1  serial output
- led  out  8  LED register
- switch  in  8  switch inputs
- digi  out  12  7-segment drive register
- irq  out  1  timer interrupt request to Control
- kernel  in  1  CPU supervisor bit (PC[31]); 1 masks irq

Behaviour:
- Register map (addr[31:0] compared exactly):
  - 0x40000000 TH
  - 0x40000004 TL
  - 0x40000008 TCON[2:0]
  - 0x4000000C led
  - 0x40000010 switch (RO)
  - 0x40000014 digi
  - 0x40000018 TXD[7:0]
  - 0x4000001C RXD[7:0] (RO)
  - 0x40000020 UCON[2:0]
- Other addresses: reads return 0, writes are ignored.
- Reads: rdata = selected register zero-extended when rd = 1, else 0; same-cycle, no wait states.
- Writes: take effect at the posedge where wr = 1.
- Reset values: TH = TL = 0, TCON = 0, led = 0, digi = 0, UART_TX = 1, irq = 0, RXD = 0, UCON = 0. Both UART FSMs go to IDLE. Reset mid-frame aborts the frame immediately.
- Timer:
  - TCON[0] enable, TCON[1] interrupt enable, TCON[2] interrupt status.
  - When enabled, each cycle: if TL == 0xFFFFFFFF, TL <= TH and TCON[2] <= TCON[2] | TCON[1]; else TL <= TL + 1.
  - A bus write to TL or TCON in the same cycle overrides the hardware update.
  - irq = TCON[1] & TCON[2] & ~kernel (combinational). Software clears status by writing TCON[2] = 0.
- UART TX FSM, states IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE:
  - Each state lasts BAUD_DIV cycles.
  - A write to TXD in IDLE latches wdata[7:0] and enters START next cycle; UART_TX drops to 0 on that cycle.
  - A write to TXD while not IDLE is ignored.
  - UCON[2] = busy (1 whenever state != IDLE, read-only).
  - On STOP completion UCON[0] (tx_done) <= 1.
- UART RX FSM, states IDLE -> START -> DATA -> STOP:
  - UART_RX passes through a 2-flop synchronizer before use.
  - A falling edge in IDLE starts a half-bit count (BAUD_DIV/2). If the line is still 0 the FSM moves to DATA, else returns to IDLE (glitch reject).
  - Data bits are sampled every BAUD_DIV cycles at mid-bit.
  - At the stop sample: if the line = 1, RXD <= byte and UCON[1] (rx_valid) <= 1; if 0 (framing error), the byte is discarded.
  - Overrun: a new byte overwrites RXD and rx_valid stays 1.
- Flag clearing:
  - A read of UCON clears UCON[0]; a read of RXD clears UCON[1].
  - If a set and a read-clear fall on the same cycle, set wins.
- UCON writes are ignored; all UCON bits are hardware-owned.

Test Plan:
- Reset: reset = 0 mid-TX-frame -> UART_TX = 1, irq = 0, all registers 0; after release, rd 0x40000020 -> 0.
- Timer: write TH = 0xFFFFFFFC, TL = 0xFFFFFFFE, TCON = 3, kernel = 0.
  - -> TL = 0xFFFFFFFF one cycle later, then 0xFFFFFFFC.
  - -> irq = 1 in the cycle after reload.
  - -> kernel = 1 forces irq = 0.
  - -> write TCON = 3 clears irq.
- TX: BAUD_DIV = 8, write TXD = 0xA5.
  - -> UART_TX sequence 0,1,0,1,0,0,1,0,1,1, each held 8 cycles.
  - -> UCON reads 0x4 during the frame, 0x1 after.
  - -> a second UCON read returns 0.
- TX busy: write TXD = 0x3C mid-frame -> ignored; the line still carries 0xA5.
- RX: drive frame 0x5A at BAUD_DIV = 8.
  - -> UCON[1] = 1, RXD read = 0x0000005A, then UCON[1] = 0.
  - 2-cycle RX low pulse -> no reception.
  - Stop bit = 0 -> rx_valid stays 0.
- Bus misc:
  - switch = 0x81, rd 0x40000010 -> 0x81.
  - Write led = 0x1FF -> led = 0xFF.
  - rd 0x40000024 -> 0.
  - rd = 0 -> rdata = 0.
